// File: rtl/alu_req_sched.sv
// Two-requester scheduler for a shared combinational ALU: round-robin accept,
// registered ALU drive with a multicycle hold for multiplies, and result return.
module alu_req_sched #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [3:0]  op0,
  input  logic [3:0]  op1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic [4:0]  sh0,
  input  logic [4:0]  sh1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] res_lo,
  output logic [31:0] res_hi,
  output logic [3:0]  res_flags,
  output logic        err,
  output logic [3:0]  flags,
  output logic        busy,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctl,
  output logic [4:0]  alu_sh,
  input  logic [31:0] alu_res,
  input  logic [31:0] alu_res1,
  input  logic        alu_z,
  input  logic        alu_c,
  input  logic        alu_s,
  input  logic        alu_v
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_t     state;
  state_t     state_next;
  logic       last;
  logic       id;
  logic       win;
  logic       accept;
  logic       capture;
  logic       illegal;
  logic       op_mul;
  logic       win_mul;
  logic [3:0] win_op;
  logic [3:0] cnt;

  // Arbitration and FSM next-state; the requester not granted last wins a tie.
  always_comb begin
    state_next = state;
    win        = (req0 & req1) ? ~last : req1;
    win_op     = win ? op1 : op0;
    win_mul    = (win_op == 4'b0001) || (win_op == 4'b0010);
    accept     = (state == IDLE) && (req0 | req1);
    capture    = (state == EXEC) && (cnt == 4'd0);
    op_mul     = (alu_ctl == 4'b0001) || (alu_ctl == 4'b0010);
    illegal    = (alu_ctl[3:2] == 2'b11);
    case (state)
      IDLE:    if (req0 | req1) state_next = EXEC;
      EXEC:    if (cnt == 4'd0) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The alu_* outputs are the latched request, so they only move at an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      last      <= 1'b1;
      id        <= 1'b0;
      cnt       <= 4'd0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      res_lo    <= 32'd0;
      res_hi    <= 32'd0;
      res_flags <= 4'd0;
      err       <= 1'b0;
      flags     <= 4'd0;
      alu_a     <= 32'd0;
      alu_b     <= 32'd0;
      alu_ctl   <= 4'd0;
      alu_sh    <= 5'd0;
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      if (accept) begin
        id      <= win;
        last    <= win;
        alu_ctl <= win_op;
        alu_a   <= win ? a1 : a0;
        alu_b   <= win ? b1 : b0;
        alu_sh  <= win ? sh1 : sh0;
        cnt     <= win_mul ? MUL_CNT : 4'd0;
        gnt0    <= ~win;
        gnt1    <= win;
      end else if ((state == EXEC) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      // Illegal opcodes return zeros with err and leave the sticky flags alone.
      if (capture) begin
        res_lo    <= illegal ? 32'd0 : alu_res;
        res_hi    <= op_mul ? {1'b0, alu_res1[30:0]} : 32'd0;
        res_flags <= illegal ? 4'd0 : {alu_z, alu_c, alu_s, alu_v};
        err       <= illegal;
        done0     <= ~id;
        done1     <= id;
        if (!illegal) flags <= {alu_z, alu_c, alu_s, alu_v};
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
